// File: rtl/mem_dump_pkg.sv
// Shared oscilloscope package (also used by mem_clear).
// Holds the dump state enumeration and the default sync header byte.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_READ,
    ST_WAIT_DATA,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/mem_dump_if.sv
// Sample-memory read port and UART byte handshake of the memory dumper.
//   mem_en / mem_addr   : one-cycle read strobe and address (master -> memory)
//   mem_rd_data         : read data, valid one cycle after mem_en
//   tx_data / tx_valid  : byte offered to the UART (held until accepted)
//   tx_ready            : UART accepts when tx_valid && tx_ready
interface mem_dump_if #(
  parameter int ADDR_W = 8
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output mem_en, mem_addr, tx_data, tx_valid,
    input  mem_rd_data, tx_ready
  );

  modport slave (
    input  mem_en, mem_addr, tx_data, tx_valid,
    output mem_rd_data, tx_ready
  );
endinterface

// File: rtl/mem_dump.sv
// Streams the whole sample memory (2**ADDR_W bytes, ascending address) to a
// UART transmitter, optionally preceded by a sync header byte.
// Ports:
//   clk_50mhz : sole clock, rising edge
//   reset     : asynchronous, active-low
//   activate  : level request; starts a dump from idle
//   done      : high while the dump is complete and activate is still high
//   bus       : mem_dump_if master (memory read port + UART handshake)
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [7:0] HEADER    = DEFAULT_HEADER
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       activate,
  output logic       done,
  mem_dump_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] count, count_nxt;
  logic [7:0]        data_q, data_nxt;

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    data_nxt  = data_q;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (activate) begin
          if (HEADER_EN) begin
            state_nxt = ST_HEADER;
            data_nxt  = HEADER;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_HEADER: begin
        if (bus.tx_ready) state_nxt = ST_READ;
      end
      ST_READ: begin
        state_nxt = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        // Memory answers one cycle after the strobe; capture it here so the
        // byte is presented with tx_valid from the next cycle on.
        data_nxt  = bus.mem_rd_data;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          // End of dump found by compare so the counter never wraps.
          if (count == LAST_ADDR) begin
            state_nxt = ST_DONE;
          end else begin
            count_nxt = count + 1'b1;
            state_nxt = ST_READ;
          end
        end
      end
      ST_DONE: begin
        if (!activate) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset clears them
  // immediately and the state after any acceptance never offers a byte.
  assign bus.tx_valid = (state == ST_HEADER) || (state == ST_SEND);
  assign bus.mem_en   = (state == ST_READ);
  assign bus.mem_addr = count;
  assign bus.tx_data  = data_q;
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_mem_dump.sv
// Randomized self-checking bench for mem_dump: memory model, expected-byte
// queue built from memory contents, and a per-cycle protocol monitor.
module tb_mem_dump;
  localparam int AW = 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic activate = 1'b0;
  logic activate0 = 1'b0;
  logic done, done0;

  mem_dump_if #(.ADDR_W(AW)) bus ();
  mem_dump_if #(.ADDR_W(AW)) bus0 ();

  mem_dump #(.ADDR_W(AW), .HEADER_EN(1'b1), .HEADER(8'hA5)) dut (
    .clk_50mhz(clk), .reset(reset), .activate(activate), .done(done), .bus(bus)
  );

  mem_dump #(.ADDR_W(AW), .HEADER_EN(1'b0), .HEADER(8'hA5)) dut0 (
    .clk_50mhz(clk), .reset(reset), .activate(activate0), .done(done0), .bus(bus0)
  );

  always #10 clk = ~clk;

  // Memory models: one registered read per strobe.
  logic [7:0] mem [N];
  always @(posedge clk) if (bus.mem_en) bus.mem_rd_data <= mem[bus.mem_addr];
  always @(posedge clk) if (bus0.mem_en) bus0.mem_rd_data <= 8'h3C;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] exp_q[$];
  int         rd_exp = 0;
  int         acc_cnt = 0;
  bit         prev_acc = 0;
  bit         hold = 0;
  bit         last_acc = 0;
  logic [7:0] hold_data = '0;
  logic [7:0] e;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_acc) chk("gap_after_accept", bus.tx_valid, 0);
      if (hold) begin
        chk("hold_valid", bus.tx_valid, 1);
        chk("hold_data", bus.tx_data, hold_data);
      end
      if (last_acc) chk("done_after_last", done, 1);
      if (bus.mem_en) begin
        chk("mem_en_while_valid", bus.tx_valid, 0);
        chk("rd_in_range", rd_exp < N, 1);
        chk("rd_addr", bus.mem_addr, rd_exp);
        rd_exp++;
      end
      hold      = bus.tx_valid && !bus.tx_ready;
      hold_data = bus.tx_data;
      prev_acc  = bus.tx_valid && bus.tx_ready;
      last_acc  = 0;
      if (prev_acc) begin
        chk("byte_expected", exp_q.size() > 0, 1);
        chk("done_low_in_dump", done, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("byte", bus.tx_data, e);
          acc_cnt++;
          last_acc = (exp_q.size() == 0);
        end
      end
    end else begin
      prev_acc = 0;
      hold     = 0;
      last_acc = 0;
    end
  end

  // HEADER_EN=0 instance: count bytes and anything that is not 3C.
  int cnt0 = 0;
  int bad0 = 0;
  always @(negedge clk) begin
    if (reset && bus0.tx_valid && bus0.tx_ready) begin
      cnt0++;
      if (bus0.tx_data != 8'h3C) bad0++;
    end
  end

  // tx_ready driver: 0 = always ready, 1 = random, 2 = stall 10 cycles on 0x10
  int ready_mode = 0;
  int stall_cnt = 0;
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (bus.tx_valid && bus.tx_data == 8'h10 && stall_cnt < 10) begin
            bus.tx_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.tx_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_model(input bit hdr);
    exp_q.delete();
    if (hdr) exp_q.push_back(8'hA5);
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
    rd_exp  = 0;
    acc_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("dump_finished", done, 1);
    chk("bytes_remaining", exp_q.size(), 0);
    chk("total_bytes", acc_cnt, N + 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.tx_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = i[7:0];

    // Reset values
    repeat (3) tick();
    chk("rst_done", done, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    reset = 1'b1;
    repeat (4) tick();
    chk("idle_tx_valid", bus.tx_valid, 0);
    chk("idle_mem_en", bus.mem_en, 0);

    // Identity memory, always ready
    load_model(1);
    activate = 1'b1;
    wait_done(4000);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("done_hold", done, 1);
      chk("done_no_valid", bus.tx_valid, 0);
      chk("done_no_mem_en", bus.mem_en, 0);
    end
    activate = 1'b0;
    tick();
    chk("done_fall", done, 0);

    // HEADER_EN = 0 instance
    activate0 = 1'b1;
    for (int k = 0; k < 4000 && done0 !== 1'b1; k++) tick();
    chk("nohdr_done", done0, 1);
    chk("nohdr_count", cnt0, N);
    chk("nohdr_bad_bytes", bad0, 0);
    activate0 = 1'b0;
    tick();
    chk("nohdr_done_fall", done0, 0);

    // Random memory, random ready
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    ready_mode = 1;
    load_model(1);
    activate = 1'b1;
    wait_done(6000);
    activate = 1'b0;
    tick();
    chk("rand_done_fall", done, 0);

    // Back-pressure stall on byte 0x10
    for (int i = 0; i < N; i++) mem[i] = i[7:0];
    ready_mode = 2;
    stall_cnt = 0;
    load_model(1);
    activate = 1'b1;
    wait_done(4000);
    chk("stall_cycles", stall_cnt, 10);
    activate = 1'b0;
    tick();

    // activate dropped after byte 5
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    ready_mode = 1;
    load_model(1);
    activate = 1'b1;
    for (int k = 0; k < 200 && acc_cnt < 7; k++) tick();
    chk("drop_reached_byte5", acc_cnt >= 7, 1);
    activate = 1'b0;
    wait_done(6000);
    tick();
    chk("drop_done_one_cycle", done, 0);
    repeat (5) tick();
    chk("drop_stay_idle_valid", bus.tx_valid, 0);
    chk("drop_stay_idle_mem_en", bus.mem_en, 0);

    // Reset during byte 0x80, restart with activate held high
    for (int i = 0; i < N; i++) mem[i] = i[7:0];
    load_model(1);
    activate = 1'b1;
    begin
      int k = 0;
      while (!(bus.tx_valid && bus.tx_data == 8'h80) && k < 4000) begin
        tick();
        k++;
      end
    end
    chk("mid_reached_0x80", bus.tx_data, 8'h80);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_tx_valid", bus.tx_valid, 0);
    chk("mid_rst_tx_data", bus.tx_data, 0);
    chk("mid_rst_mem_en", bus.mem_en, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    chk("mid_rst_done", done, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("in_rst_valid", bus.tx_valid, 0);
      chk("in_rst_mem_en", bus.mem_en, 0);
    end
    load_model(1);
    reset = 1'b1;
    wait_done(6000);
    activate = 1'b0;
    tick();
    chk("restart_done_fall", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning memory address width (dump length 2**ADDR_W bytes).
REQ-002 The block SHALL have parameter HEADER_EN, default 1, meaning a sync byte is sent before the dump.
REQ-003 The block SHALL have parameter HEADER, default 8'hA5, meaning the sync byte value.
REQ-004 Port: clk_50mhz  input  1  sole clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: activate  input  1  level request; high starts a dump from IDLE.
REQ-007 Port: done  output  1  high while the dump is complete and activate is still high.
REQ-008 Port: mem_en  output  1  one-cycle read strobe to the sample memory.
REQ-009 Port: mem_addr  output  ADDR_W  read address, valid while mem_en is high.
REQ-010 Port: mem_rd_data  input  8  read data, valid exactly one cycle after mem_en.
REQ-011 Port: tx_data  output  8  byte to the UART transmitter.
REQ-012 Port: tx_valid  output  1  tx_data is valid; held until accepted.
REQ-013 Port: tx_ready  input  1  transmitter accepts the byte in any cycle where tx_valid and tx_ready are both high.

Function
REQ-014 States: IDLE, HEADER, READ, WAIT_DATA, SEND, DONE.
REQ-015 IDLE: done=0, tx_valid=0, mem_en=0, address counter=0; activate=1 -> HEADER if HEADER_EN else READ.
REQ-016 HEADER: tx_data=HEADER, tx_valid=1; on acceptance -> READ next cycle.
REQ-017 READ: mem_en=1 for exactly one cycle with mem_addr=counter -> WAIT_DATA.
REQ-018 WAIT_DATA: register mem_rd_data into tx_data, assert tx_valid on the following cycle -> SEND.
REQ-019 SEND: tx_data and tx_valid stable until acceptance; on acceptance, counter==2**ADDR_W-1 -> DONE, else counter+1 -> READ.
REQ-020 tx_valid SHALL be low in the cycle after any acceptance (no back-to-back bytes; minimum 3 cycles per data byte).
REQ-021 Bytes SHALL be sent in ascending address order 0..2**ADDR_W-1, each exactly once; total bytes = 2**ADDR_W + HEADER_EN.
REQ-022 The counter SHALL NOT wrap; the last address is detected by compare, not by overflow.
REQ-023 DONE: done=1, mem_en=0, tx_valid=0; activate=0 -> IDLE (done falls next cycle).
REQ-024 activate deasserted mid-dump SHALL be ignored; the dump completes, then DONE holds done for one cycle and returns to IDLE.
REQ-025 tx_ready high while tx_valid is low SHALL have no effect.
REQ-026 mem_en SHALL never be asserted while tx_valid is high.

Reset
REQ-027 reset low SHALL asynchronously force state IDLE, counter 0, done=0, mem_en=0, mem_addr=0, tx_valid=0, tx_data=0.
REQ-028 Reset mid-dump SHALL abort without a further tx_valid or mem_en pulse; after release, a new dump starts from address 0 only if activate is high.

Structure
REQ-029 The state enumeration and the default HEADER constant SHALL live in the shared oscilloscope package used with mem_clear.
REQ-030 The block SHALL be a single module with no sub-modules; the UART transmitter and memory are external.

Verification
REQ-031 Memory preloaded mem[i]=i, tx_ready tied 1, activate=1 -> A5,00,01..FF transmitted, 257 bytes total, done=1 after the last acceptance.
REQ-032 HEADER_EN=0, mem[i]=8'h3C -> exactly 256 bytes of 3C, no A5.
REQ-033 tx_ready held low 10 cycles during byte 0x10 -> tx_data stays 0x10 with tx_valid high, no mem_en pulse, 0x11 follows after release.
REQ-034 activate dropped after byte 5 -> all 256 data bytes still sent, done high exactly one cycle, then IDLE.
REQ-035 reset low during byte 0x80 -> outputs zero immediately; activate high after release -> dump restarts with A5, 00.
REQ-036 done=1, activate held high 20 cycles -> done stays 1, no new mem_en or tx_valid; activate low -> done 0 next cycle.
